// File: rtl/flush_sequencer_pkg.sv
// Shared types and default constants for the flush sequencer.
package flush_sequencer_pkg;

  // Sequencer phases; each grant walks IDLE -> ASSERT -> DRAIN -> ACK -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    DRAIN  = 2'd2,
    ACK    = 2'd3
  } flush_state_t;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_DRAIN_CYCLES = 1;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flush_sequencer_if.sv
// Request/ack/flush bundle between the flush requesters and the sequencer.
interface flush_sequencer_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] flush_req;
  logic [NUM_REQ-1:0] flush_ack;
  logic               flush;
  logic               busy;
  logic [ID_W-1:0]    grant_id;

  // Requester side: raises levels, watches the shared flush line and acks.
  modport master (
    output flush_req,
    input  flush_ack,
    input  flush,
    input  busy,
    input  grant_id
  );

  // Sequencer side.
  modport slave (
    input  flush_req,
    output flush_ack,
    output flush,
    output busy,
    output grant_id
  );
endinterface

// File: rtl/flush_sequencer_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the pointer
// and the first asserted request found (wrapping modulo NUM_REQ) wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               valid_o
);

  logic [ID_W-1:0] idx_s;
  logic            hit_s;

  // Scan from farthest to nearest so the nearest requester past the pointer overwrites.
  always_comb begin
    winner_o = {ID_W{1'b0}};
    valid_o  = 1'b0;
    idx_s    = {ID_W{1'b0}};
    hit_s    = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx_s    = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      hit_s    = req_i[idx_s];
      winner_o = hit_s ? idx_s : winner_o;
      valid_o  = valid_o | hit_s;
    end
  end

endmodule

// File: rtl/flush_sequencer.sv
// Arbitrates flush requests and sequences the shared flush line:
// flush for FLUSH_CYCLES, settle for DRAIN_CYCLES, then a one-cycle ack
// to the granted requester. All outputs come straight from flops.
module flush_sequencer
  import flush_sequencer_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input logic              clk,
  input logic              rst_n,
  flush_sequencer_if.slave fs_if
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(FLUSH_CYCLES, DRAIN_CYCLES) + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
  localparam logic [ID_W-1:0]  PTR_RESET  = ID_W'(NUM_REQ - 1);

  flush_state_t       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic               flush_q, flush_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;

  logic [ID_W-1:0]    win_id_s;
  logic               win_valid_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i    (fs_if.flush_req),
    .ptr_i    (ptr_q),
    .winner_o (win_id_s),
    .valid_o  (win_valid_s)
  );

  // Next-state, counter reload, grant latch and pointer update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          state_d = ASSERT;
          cnt_d   = FLUSH_LOAD;
          grant_d = win_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      ASSERT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          if (DRAIN_CYCLES > 0) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = ACK;
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        // Served requester moves to lowest priority for the next search.
        state_d = IDLE;
        ptr_d   = grant_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output values are decoded from the next state so the flops line up with it.
  always_comb begin
    flush_d = (state_d == ASSERT);
    busy_d  = (state_d != IDLE);
    ack_d   = {NUM_REQ{1'b0}};
    if (state_d == ACK) begin
      ack_d[grant_d] = 1'b1;
    end else begin
      ack_d = {NUM_REQ{1'b0}};
    end
  end

  // State, counter, pointer and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ptr_q   <= PTR_RESET;
      grant_q <= {ID_W{1'b0}};
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= {NUM_REQ{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign fs_if.flush     = flush_q;
  assign fs_if.busy      = busy_q;
  assign fs_if.flush_ack = ack_q;
  assign fs_if.grant_id  = grant_q;

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer (NUM_REQ=4, FLUSH=2, DRAIN=1) plus a
// DRAIN_CYCLES=0 instance sharing clock and reset.
module tb_flush_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  flush_sequencer_if #(.NUM_REQ(4)) fs_if ();
  flush_sequencer_if #(.NUM_REQ(4)) fs0_if ();

  flush_sequencer #(.NUM_REQ(4), .FLUSH_CYCLES(2), .DRAIN_CYCLES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fs_if (fs_if)
  );

  flush_sequencer #(.NUM_REQ(4), .FLUSH_CYCLES(2), .DRAIN_CYCLES(0)) dut_d0 (
    .clk   (clk),
    .rst_n (rst_n),
    .fs_if (fs0_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fs_if.flush_req  = 4'b0000;
    fs0_if.flush_req = 4'b0000;
    repeat (3) tick();
    total++; if (fs_if.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b want=0", fs_if.flush); end
    total++; if (fs_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", fs_if.busy); end
    total++; if (fs_if.flush_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", fs_if.flush_ack); end
    total++; if (fs_if.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", fs_if.grant_id); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [5:0] ef = 6'b000011;
    logic [5:0] eb = 6'b001111;
    logic [3:0] ea;
    fs_if.flush_req = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      ea = (k == 4) ? 4'b0100 : 4'b0000;
      total++; if (fs_if.flush !== ef[k-1]) begin bad++; $display("FAIL single_flush k=%0d got=%0b want=%0b", k, fs_if.flush, ef[k-1]); end
      total++; if (fs_if.busy !== eb[k-1]) begin bad++; $display("FAIL single_busy k=%0d got=%0b want=%0b", k, fs_if.busy, eb[k-1]); end
      total++; if (fs_if.flush_ack !== ea) begin bad++; $display("FAIL single_ack k=%0d got=%b want=%b", k, fs_if.flush_ack, ea); end
      if (k <= 4) begin
        total++; if (fs_if.grant_id !== 2'd2) begin bad++; $display("FAIL single_grant k=%0d got=%0d want=2", k, fs_if.grant_id); end
      end
      if (k == 4) fs_if.flush_req = 4'b0000;
    end
  endtask

  task automatic test_fairness();
    int cyc  = 0;
    int n    = 0;
    int last = 0;
    logic [3:0] ea;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fs_if.flush_req = 4'b1111;
    while (n < 5 && cyc < 60) begin
      tick();
      cyc++;
      total++; if ((fs_if.flush & (|fs_if.flush_ack)) !== 1'b0) begin bad++; $display("FAIL fair_overlap cyc=%0d flush=%0b ack=%b want no overlap", cyc, fs_if.flush, fs_if.flush_ack); end
      if (fs_if.flush_ack !== 4'b0000) begin
        ea = 4'b0001 << (n % 4);
        total++; if (fs_if.flush_ack !== ea) begin bad++; $display("FAIL fair_order n=%0d got=%b want=%b", n, fs_if.flush_ack, ea); end
        if (n == 0) begin
          total++; if (cyc !== 4) begin bad++; $display("FAIL fair_first_ack got=%0d want=4", cyc); end
        end else begin
          total++; if ((cyc - last) !== 5) begin bad++; $display("FAIL fair_spacing n=%0d got=%0d want=5", n, cyc - last); end
        end
        last = cyc;
        n++;
        if (n == 5) fs_if.flush_req = 4'b0000;
      end
    end
    total++; if (n !== 5) begin bad++; $display("FAIL fair_timeout acks got=%0d want=5", n); end
    fs_if.flush_req = 4'b0000;
    tick();
  endtask

  task automatic test_drain0();
    logic [4:0] ef = 5'b00011;
    logic [4:0] eb = 5'b00111;
    logic [3:0] ea;
    fs0_if.flush_req = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ea = (k == 3) ? 4'b0010 : 4'b0000;
      total++; if (fs0_if.flush !== ef[k-1]) begin bad++; $display("FAIL drain0_flush k=%0d got=%0b want=%0b", k, fs0_if.flush, ef[k-1]); end
      total++; if (fs0_if.busy !== eb[k-1]) begin bad++; $display("FAIL drain0_busy k=%0d got=%0b want=%0b", k, fs0_if.busy, eb[k-1]); end
      total++; if (fs0_if.flush_ack !== ea) begin bad++; $display("FAIL drain0_ack k=%0d got=%b want=%b", k, fs0_if.flush_ack, ea); end
      if (k <= 3) begin
        total++; if (fs0_if.grant_id !== 2'd1) begin bad++; $display("FAIL drain0_grant k=%0d got=%0d want=1", k, fs0_if.grant_id); end
      end
      if (k == 3) fs0_if.flush_req = 4'b0000;
    end
  endtask

  task automatic test_withdraw();
    logic [4:0] ef = 5'b00011;
    logic [4:0] eb = 5'b01111;
    logic [3:0] ea;
    fs_if.flush_req = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ea = (k == 4) ? 4'b0010 : 4'b0000;
      total++; if (fs_if.flush !== ef[k-1]) begin bad++; $display("FAIL withdraw_flush k=%0d got=%0b want=%0b", k, fs_if.flush, ef[k-1]); end
      total++; if (fs_if.busy !== eb[k-1]) begin bad++; $display("FAIL withdraw_busy k=%0d got=%0b want=%0b", k, fs_if.busy, eb[k-1]); end
      total++; if (fs_if.flush_ack !== ea) begin bad++; $display("FAIL withdraw_ack k=%0d got=%b want=%b", k, fs_if.flush_ack, ea); end
      if (k <= 4) begin
        total++; if (fs_if.grant_id !== 2'd1) begin bad++; $display("FAIL withdraw_grant k=%0d got=%0d want=1", k, fs_if.grant_id); end
      end
      if (k == 2) fs_if.flush_req = 4'b0000;
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] ef = 5'b00011;
    logic [4:0] eb = 5'b01111;
    logic [3:0] ea;
    fs_if.flush_req = 4'b1000;
    tick();
    tick();
    total++; if (fs_if.flush !== 1'b1) begin bad++; $display("FAIL areset_pre_flush got=%0b want=1", fs_if.flush); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (fs_if.flush !== 1'b0) begin bad++; $display("FAIL areset_flush_drop got=%0b want=0", fs_if.flush); end
    total++; if (fs_if.busy !== 1'b0) begin bad++; $display("FAIL areset_busy_drop got=%0b want=0", fs_if.busy); end
    total++; if (fs_if.flush_ack !== 4'b0000) begin bad++; $display("FAIL areset_ack got=%b want=0000", fs_if.flush_ack); end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (fs_if.flush_ack !== 4'b0000) begin bad++; $display("FAIL areset_hold_ack k=%0d got=%b want=0000", k, fs_if.flush_ack); end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      ea = (k == 4) ? 4'b1000 : 4'b0000;
      total++; if (fs_if.flush !== ef[k-1]) begin bad++; $display("FAIL restart_flush k=%0d got=%0b want=%0b", k, fs_if.flush, ef[k-1]); end
      total++; if (fs_if.busy !== eb[k-1]) begin bad++; $display("FAIL restart_busy k=%0d got=%0b want=%0b", k, fs_if.busy, eb[k-1]); end
      total++; if (fs_if.flush_ack !== ea) begin bad++; $display("FAIL restart_ack k=%0d got=%b want=%b", k, fs_if.flush_ack, ea); end
      if (k <= 4) begin
        total++; if (fs_if.grant_id !== 2'd3) begin bad++; $display("FAIL restart_grant k=%0d got=%0d want=3", k, fs_if.grant_id); end
      end
      if (k == 4) fs_if.flush_req = 4'b0000;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fs_if.flush_req  = 4'b0000;
    fs0_if.flush_req = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_drain0();
    test_withdraw();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
